// File: rtl/aes_inv_cipher_state_if.sv
// Request/result bundle for the iterative AES inverse cipher: ciphertext in with a
// start strobe, state register out with ready pulse and busy flag.
interface aes_inv_cipher_state_if #(
    parameter int Nb = 4
);
    logic [0:4*Nb-1][7:0] Data_in;
    logic                 Enable;
    logic [0:4*Nb-1][7:0] Data_out;
    logic                 Ready_out;
    logic                 Busy_out;

    modport master (
        output Data_in,
        output Enable,
        input  Data_out,
        input  Ready_out,
        input  Busy_out
    );

    modport slave (
        input  Data_in,
        input  Enable,
        output Data_out,
        output Ready_out,
        output Busy_out
    );
endinterface

// File: rtl/aes_inv_cipher_state.sv
// Iterative AES inverse cipher: one round per clock, round keys Nr down to 0,
// all GF(2^8) products resolved through the supplied log/antilog tables.
module aes_inv_cipher_state #(
    parameter int Nb = 4,
    parameter int Nr = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  InvSBox [0:255],
    input  logic [7:0]  EXP3    [0:255],
    input  logic [7:0]  LN3     [0:255],
    input  logic [31:0] KExp    [0:Nb*(Nr+1)-1],
    aes_inv_cipher_state_if.slave bus
);
    localparam int NBYTES = 4 * Nb;
    localparam int KW     = $clog2(Nb * (Nr + 1));
    localparam logic [7:0] COEF [0:3] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    typedef enum logic [1:0] {
        PH_LOAD,
        PH_ROUND,
        PH_FINAL
    } phase_t;

    logic [3:0]              state_reg, state_next;
    logic                    ready_reg, ready_next;
    logic                    busy_reg, busy_next;
    logic [0:NBYTES-1][7:0]  s_reg, s_next;
    phase_t                  phase;

    logic [KW-1:0] key_word;
    logic [7:0]    rk   [0:NBYTES-1];
    logic [7:0]    isr  [0:NBYTES-1];
    logic [7:0]    sub  [0:NBYTES-1];
    logic [7:0]    ark  [0:NBYTES-1];
    logic [7:0]    imc  [0:NBYTES-1];
    logic [7:0]    prod [0:NBYTES-1][0:3];

    // Key index is Nr - state in every phase: Nr at load, 0 on the final round.
    assign key_word = KW'((Nr - int'(state_reg)) * Nb);

    genvar gi, gk;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            localparam int C = gi / 4;
            localparam int R = gi % 4;

            assign rk[gi]  = KExp[key_word + KW'(C)][31-8*R -: 8];
            assign isr[gi] = s_reg[4*((C - R + 4) % 4) + R];
            assign sub[gi] = InvSBox[isr[gi]];
            assign ark[gi] = sub[gi] ^ rk[gi];

            // prod[gi][gk] = ark[gi] * COEF[gk], zero operand short-circuits the log domain.
            for (gk = 0; gk < 4; gk++) begin : g_coef
                logic [8:0] lsum;
                logic [7:0] lidx;
                assign lsum = {1'b0, LN3[ark[gi]]} + {1'b0, LN3[COEF[gk]]};
                assign lidx = (lsum >= 9'd255) ? 8'(lsum - 9'd255) : lsum[7:0];
                assign prod[gi][gk] = (ark[gi] == 8'd0) ? 8'd0 : EXP3[lidx];
            end

            assign imc[gi] = prod[4*C+0][(0 - R + 4) % 4]
                           ^ prod[4*C+1][(1 - R + 4) % 4]
                           ^ prod[4*C+2][(2 - R + 4) % 4]
                           ^ prod[4*C+3][(3 - R + 4) % 4];
        end
    endgenerate

    always_comb begin
        if (state_reg == 4'd0) begin
            phase = PH_LOAD;
        end else if (state_reg == 4'(Nr)) begin
            phase = PH_FINAL;
        end else begin
            phase = PH_ROUND;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready_next = 1'b0;
        busy_next  = busy_reg;
        s_next     = s_reg;
        case (phase)
            PH_LOAD: begin
                if (bus.Enable) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        s_next[i] = bus.Data_in[i] ^ rk[i];
                    end
                    state_next = 4'd1;
                    busy_next  = 1'b1;
                end
            end
            PH_ROUND: begin
                for (int i = 0; i < NBYTES; i++) begin
                    s_next[i] = imc[i];
                end
                state_next = state_reg + 4'd1;
            end
            PH_FINAL: begin
                for (int i = 0; i < NBYTES; i++) begin
                    s_next[i] = ark[i];
                end
                state_next = 4'd0;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= 4'd0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            s_reg     <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
            s_reg     <= s_next;
        end
    end

    assign bus.Data_out  = s_reg;
    assign bus.Ready_out = ready_reg;
    assign bus.Busy_out  = busy_reg;
endmodule

// File: tb/tb_aes_inv_cipher_state.sv
// Bench for aes_inv_cipher_state: builds the AES tables and a software encryptor,
// drives vectors and sequences, and checks results through a scoreboard queue.
module tb_aes_inv_cipher_state #(
    parameter int NR = 10
);
    localparam int NK = NR - 6;
    localparam int NW = 4 * (NR + 1);

    typedef logic [0:15][7:0] blk_t;
    typedef logic [0:31][7:0] key_t;
    typedef struct {
        key_t key;
        blk_t ct;
        blk_t pt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inv_sbox [0:255];
    logic [7:0]  sbox     [0:255];
    logic [7:0]  exp3     [0:255];
    logic [7:0]  ln3      [0:255];
    logic [31:0] kexp     [0:NW-1];

    int   total = 0;
    int   bad = 0;
    int   n_req = 0;
    int   rdy_cnt = 0;
    int   cyc = 0;
    blk_t exp_q [$];
    int   rdy_cyc [$];
    blk_t mon_exp;
    vec_t vec [4];

    aes_inv_cipher_state_if #(.Nb(4)) bus ();

    aes_inv_cipher_state #(.Nb(4), .Nr(NR)) dut (
        .clk     (clk),
        .rst     (rst),
        .InvSBox (inv_sbox),
        .EXP3    (exp3),
        .LN3     (ln3),
        .KExp    (kexp),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Scoreboard: every Ready_out pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.Ready_out === 1'b1) begin
            rdy_cnt++;
            rdy_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got Ready_out=1 with nothing pending, required 0");
            end else begin
                mon_exp = exp_q.pop_front();
                check("plaintext", bus.Data_out, mon_exp);
                $display("result cyc=%0d data=%h expected=%h", cyc, bus.Data_out, mon_exp);
            end
        end
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_tables();
        logic [7:0] v;
        logic [7:0] inv;
        logic [7:0] s;
        v = 8'h01;
        for (int i = 0; i < 256; i++) ln3[i] = 8'h00;
        for (int i = 0; i < 255; i++) begin
            exp3[i] = v;
            ln3[v]  = 8'(i);
            v = gmul(v, 8'h03);
        end
        exp3[255] = 8'h01;
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : exp3[(255 - int'(ln3[x])) % 255];
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x] = s;
            inv_sbox[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input key_t key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < NK; i++) kexp[i] = {key[4*i], key[4*i+1], key[4*i+2], key[4*i+3]};
        for (int i = NK; i < NW; i++) begin
            t = kexp[i-1];
            if (i % NK == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (NK > 6 && i % NK == 4) begin
                t = sub_word(t);
            end
            kexp[i] = kexp[i-NK] ^ t;
        end
    endtask

    function automatic blk_t round_key(input int r);
        blk_t k;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++)
                k[4*c+j] = kexp[4*r+c][31-8*j -: 8];
        return k;
    endfunction

    // Forward FIPS-197 Cipher, used only to manufacture ciphertexts.
    function automatic blk_t encrypt(input blk_t p);
        blk_t s;
        blk_t t;
        logic [7:0] a0, a1, a2, a3;
        s = p ^ round_key(0);
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[4*c+j] = t[4*((c + j) % 4) + j];
            if (r != NR) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            s = s ^ round_key(r);
        end
        return s;
    endfunction

    function automatic blk_t rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic key_t rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one request from idle and follow it to its Ready_out cycle.
    task automatic run_one(input blk_t ct, input blk_t pt, input string tag);
        int lat;
        int busy_n;
        bus.Data_in = ct;
        bus.Enable  = 1'b1;
        exp_q.push_back(pt);
        n_req++;
        @(posedge clk); #1;
        bus.Enable = 1'b0;
        lat = 0;
        busy_n = 0;
        while (bus.Ready_out !== 1'b1 && lat < NR + 8) begin
            if (bus.Busy_out === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("%s_latency", tag), 128'(lat + 1), 128'(NR + 1));
        check($sformatf("%s_busy_cycles", tag), 128'(busy_n), 128'(NR));
        check($sformatf("%s_busy_at_ready", tag), 128'(bus.Busy_out), 128'd0);
    endtask

    initial begin
        blk_t p;
        key_t k;
        rst = 1'b0;
        bus.Enable  = 1'b0;
        bus.Data_in = '0;
        build_tables();
        for (int i = 0; i < NW; i++) kexp[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", bus.Data_out, 128'd0);
        check("reset_ready", 128'(bus.Ready_out), 128'd0);
        check("reset_busy", 128'(bus.Busy_out), 128'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        vec[0].key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        vec[0].pt  = 128'h00112233445566778899aabbccddeeff;
        case (NR)
            12:      vec[0].ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            14:      vec[0].ct = 128'h8ea2b7ca516745bfeafc49904b496089;
            default: vec[0].ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        endcase
        vec[1].key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        vec[1].pt  = 128'h3243f6a8885a308d313198a2e0370734;
        vec[2].key = '1;
        vec[2].pt  = '0;
        vec[3].key = rand_key();
        vec[3].pt  = '1;
        for (int i = 1; i < 4; i++) begin
            expand_key(vec[i].key);
            vec[i].ct = encrypt(vec[i].pt);
        end
        if (NR == 10) vec[1].ct = 128'h3925841d02dc09fbdc118597196a0b32;

        for (int i = 0; i < 4; i++) begin
            expand_key(vec[i].key);
            run_one(vec[i].ct, vec[i].pt, $sformatf("vec%0d", i));
            @(posedge clk); #1;
        end

        // Result must persist with Enable low and no further ready pulses.
        expand_key(vec[0].key);
        run_one(vec[0].ct, vec[0].pt, "hold");
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("hold_data", bus.Data_out, vec[0].pt);
            check("hold_ready", 128'(bus.Ready_out), 128'd0);
        end

        // Enable held high with fresh Data_in each cycle: only idle-cycle blocks count.
        for (int c = 0; c < 2 * (NR + 1); c++) begin
            if (c % (NR + 1) == 0) begin
                p = rand_blk();
                bus.Data_in = encrypt(p);
                exp_q.push_back(p);
                n_req++;
            end else begin
                bus.Data_in = rand_blk();
            end
            bus.Enable = 1'b1;
            @(posedge clk); #1;
        end
        bus.Enable = 1'b0;
        @(posedge clk); #1;
        if (rdy_cyc.size() >= 2) begin
            check("b2b_spacing", 128'(rdy_cyc[rdy_cyc.size()-1] - rdy_cyc[rdy_cyc.size()-2]), 128'(NR + 1));
        end else begin
            total++;
            bad++;
            $display("FAIL b2b_spacing: got %0d ready pulses, required at least 2", rdy_cyc.size());
        end
        check("b2b_busy_after", 128'(bus.Busy_out), 128'd0);

        // Abort mid-flight: no ready pulse may follow.
        bus.Data_in = vec[0].ct;
        bus.Enable  = 1'b1;
        @(posedge clk); #1;
        bus.Enable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort_data_out", bus.Data_out, 128'd0);
        check("abort_busy", 128'(bus.Busy_out), 128'd0);
        check("abort_ready", 128'(bus.Ready_out), 128'd0);
        repeat (NR + 4) @(posedge clk);
        #1;
        check("abort_busy_later", 128'(bus.Busy_out), 128'd0);
        run_one(vec[0].ct, vec[0].pt, "after_abort");
        @(posedge clk); #1;

        for (int n = 0; n < 1000; n++) begin
            k = rand_key();
            expand_key(k);
            p = rand_blk();
            run_one(encrypt(p), p, "rand");
        end

        repeat (3) @(posedge clk);
        #1;
        check("ready_count", 128'(rdy_cnt), 128'(n_req));
        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
